// File: rtl/mem_common_pkg.sv
// ---------------------------------------------------------------------------
// mem_common
//   Shared types for the instruction-cache request arbiter.
//   - t_ic_src  : source tag of an in-flight icache request (demand / prefetch)
//   - t_ic_line : line address for the default 32-bit / 64-byte-line config
//   Modules with other ADDR_W / LINE_BYTES settings derive their own line
//   width locally; t_ic_line is the common-case type used by neighbours.
// ---------------------------------------------------------------------------
package mem_common;

    localparam int IC_ADDR_W     = 32;
    localparam int IC_LINE_BYTES = 64;
    localparam int IC_OFF_W      = $clog2(IC_LINE_BYTES);

    typedef enum logic {
        IC_SRC_DMD = 1'b0,
        IC_SRC_PF  = 1'b1
    } t_ic_src;

    typedef logic [IC_ADDR_W-IC_OFF_W-1:0] t_ic_line;

endpackage

// File: rtl/ic_arb_src_fifo.sv
// ---------------------------------------------------------------------------
// ic_arb_src_fifo
//   DEPTH x 1-bit FIFO recording the source (demand / prefetch) of every
//   request issued to the icache, in issue order. The head is read
//   combinationally so the response can be routed in the same cycle.
//   Push and pop may happen in the same cycle (also when full or empty
//   only in the legal direction: pop-while-full, push-while-empty).
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   push, push_src    write one source tag
//   pop               retire the head entry
//   head              source tag at the head (valid when !empty)
//   full, empty       occupancy flags
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module ic_arb_src_fifo
    import mem_common::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  t_ic_src push_src,
    input  logic    pop,
    output t_ic_src head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    t_ic_src          mem_q [DEPTH];

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // One flop per entry; only the entry under the write pointer loads.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem_q[gi] <= IC_SRC_DMD;
            end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= push_src;
            end
        end
    end

    // The arbiter never issues while the outstanding count is at MAX.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full && !pop));

endmodule

// File: rtl/ic_req_arb.sv
// ---------------------------------------------------------------------------
// ic_req_arb
//   Arbitrates the icache request port between demand misses from fe_buf
//   and a next-line prefetcher. Demand always wins. In-flight requests are
//   tracked in order so demand responses can be forwarded to fe_buf while
//   prefetch responses are dropped (the icache fills itself on prefetch).
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   flush                            cancels pending (un-issued) prefetches
//   dmd_req_valid/ready/addr         demand request from fe_buf
//   dmd_rsp_valid/addr/data          demand response to fe_buf (0-cycle)
//   ic_req_valid/addr/pf             request to icache (0-cycle issue)
//   ic_rsp_valid/addr/data           in-order icache response
//   busy                             requests in flight or prefetch pending
//   perf_dmd_cnt/perf_pf_cnt/perf_stall_cnt   saturating perf counters
//
// Configuration macro
//   ICARB_PERF_EN : build the perf counters; otherwise the perf ports are 0.
//
// Prefetch window: [pf_next, pf_end) in line units, modulo 2^(line width).
// ---------------------------------------------------------------------------
module ic_req_arb
    import mem_common::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int PF_DEPTH   = 2,
    parameter int MAX_OUTST  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    dmd_req_valid,
    output logic                    dmd_req_ready,
    input  logic [ADDR_W-1:0]       dmd_req_addr,
    output logic                    dmd_rsp_valid,
    output logic [ADDR_W-1:0]       dmd_rsp_addr,
    output logic [LINE_BYTES*8-1:0] dmd_rsp_data,
    output logic                    ic_req_valid,
    output logic [ADDR_W-1:0]       ic_req_addr,
    output logic                    ic_req_pf,
    input  logic                    ic_rsp_valid,
    input  logic [ADDR_W-1:0]       ic_rsp_addr,
    input  logic [LINE_BYTES*8-1:0] ic_rsp_data,
    output logic                    busy,
    output logic [31:0]             perf_dmd_cnt,
    output logic [31:0]             perf_pf_cnt,
    output logic [31:0]             perf_stall_cnt
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int CNT_W  = $clog2(MAX_OUTST) + 1;

    typedef logic [LINE_W-1:0] line_t;

    line_t            pf_next_q, pf_next_d;
    line_t            pf_end_q,  pf_end_d;
    logic [CNT_W-1:0] outst_q,   outst_d;

    line_t   dmd_line;
    line_t   pf_dist;
    line_t   issue_line;
    logic    outst_room;
    logic    pf_pending;
    logic    dmd_acc;
    logic    pf_iss;
    logic    issue;
    logic    rsp_pop;
    t_ic_src fifo_head;
    logic    fifo_full;
    logic    fifo_empty;

    // Byte offset inside the line is don't-care for demand requests.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dmd_req_addr[OFF_W-1:0];

    assign dmd_line   = dmd_req_addr[ADDR_W-1:OFF_W];
    assign pf_dist    = pf_next_q - dmd_line;
    assign outst_room = (outst_q < CNT_W'(MAX_OUTST));
    assign pf_pending = (pf_next_q != pf_end_q);

    // ------------------------------------------------------------------
    // Arbitration: demand strictly first, prefetch only in idle slots.
    // ready is gated by reset_n so every output reads 0 while in reset.
    // ------------------------------------------------------------------
    assign dmd_req_ready = reset_n & outst_room;
    assign dmd_acc       = dmd_req_valid & dmd_req_ready;
    assign pf_iss        = ~dmd_acc & pf_pending & outst_room & ~flush;
    assign issue         = dmd_acc | pf_iss;

    assign issue_line   = dmd_acc ? dmd_line : pf_next_q;
    assign ic_req_valid = issue;
    assign ic_req_addr  = issue ? {issue_line, {OFF_W{1'b0}}} : '0;
    assign ic_req_pf    = pf_iss;

    // ------------------------------------------------------------------
    // Prefetch window update. Flush wins over a concurrent demand: the
    // demand still issues, but the window collapses to empty.
    // A demand whose line is just behind pf_next (already-prefetched
    // region) keeps pf_next so lines are not prefetched twice.
    // ------------------------------------------------------------------
    always_comb begin
        pf_next_d = pf_next_q;
        pf_end_d  = pf_end_q;
        if (flush) begin
            pf_next_d = pf_end_q;
        end else if (dmd_acc) begin
            pf_end_d = dmd_line + LINE_W'(1 + PF_DEPTH);
            if (!((pf_dist >= LINE_W'(1)) && (pf_dist <= LINE_W'(PF_DEPTH)))) begin
                pf_next_d = dmd_line + LINE_W'(1);
            end
        end else if (pf_iss) begin
            pf_next_d = pf_next_q + LINE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outstanding counter and in-order source tracking.
    // ------------------------------------------------------------------
    assign rsp_pop = ic_rsp_valid & ~fifo_empty;

    always_comb begin
        outst_d = outst_q + CNT_W'(issue) - CNT_W'(rsp_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pf_next_q <= '0;
            pf_end_q  <= '0;
            outst_q   <= '0;
        end else begin
            pf_next_q <= pf_next_d;
            pf_end_q  <= pf_end_d;
            outst_q   <= outst_d;
        end
    end

    ic_arb_src_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_src_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (issue),
        .push_src (pf_iss ? IC_SRC_PF : IC_SRC_DMD),
        .pop      (rsp_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Response routing: forward demand responses, drop prefetch fills.
    assign dmd_rsp_valid = rsp_pop & (fifo_head == IC_SRC_DMD);
    assign dmd_rsp_addr  = ic_rsp_addr;
    assign dmd_rsp_data  = ic_rsp_data;

    assign busy = (outst_q != '0) | pf_pending;

    a_rsp_tracked : assert property (@(posedge clk) disable iff (!reset_n)
        (ic_rsp_valid |-> !fifo_empty));

    a_issue_not_full : assert property (@(posedge clk) disable iff (!reset_n)
        (issue |-> !fifo_full));

    // ------------------------------------------------------------------
    // Performance counters (saturating at all-ones).
    // ------------------------------------------------------------------
`ifdef ICARB_PERF_EN
    logic [31:0] perf_dmd_q,   perf_dmd_d;
    logic [31:0] perf_pf_q,    perf_pf_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_dmd_d   = perf_dmd_q;
        perf_pf_d    = perf_pf_q;
        perf_stall_d = perf_stall_q;
        if (dmd_acc && (perf_dmd_q != '1)) begin
            perf_dmd_d = perf_dmd_q + 32'd1;
        end
        if (pf_iss && (perf_pf_q != '1)) begin
            perf_pf_d = perf_pf_q + 32'd1;
        end
        if (dmd_req_valid && !dmd_req_ready && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_dmd_q   <= '0;
            perf_pf_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_dmd_q   <= perf_dmd_d;
            perf_pf_q    <= perf_pf_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_dmd_cnt   = perf_dmd_q;
    assign perf_pf_cnt    = perf_pf_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_dmd_cnt   = '0;
    assign perf_pf_cnt    = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ic_req_arb.sv
// ---------------------------------------------------------------------------
// tb_ic_req_arb
//   Directed bench for ic_req_arb (ADDR_W=32, LINE_BYTES=64, PF_DEPTH=2,
//   MAX_OUTST=8). A small in-order icache model answers each request five
//   cycles after issue when the current step allows it. Cycle 0 of each
//   test is the first cycle after reset release.
// ---------------------------------------------------------------------------
module tb_ic_req_arb;

    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         flush;
    logic         dmd_req_valid;
    logic         dmd_req_ready;
    logic [31:0]  dmd_req_addr;
    logic         dmd_rsp_valid;
    logic [31:0]  dmd_rsp_addr;
    logic [511:0] dmd_rsp_data;
    logic         ic_req_valid;
    logic [31:0]  ic_req_addr;
    logic         ic_req_pf;
    logic         ic_rsp_valid;
    logic [31:0]  ic_rsp_addr;
    logic [511:0] ic_rsp_data;
    logic         busy;
    logic [31:0]  perf_dmd_cnt;
    logic [31:0]  perf_pf_cnt;
    logic [31:0]  perf_stall_cnt;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;
    int cyc    = 0;

    logic [31:0] q_a[$];
    int          q_c[$];

    always #5 clk = ~clk;

    ic_req_arb #(
        .ADDR_W     (32),
        .LINE_BYTES (64),
        .PF_DEPTH   (2),
        .MAX_OUTST  (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .dmd_req_valid  (dmd_req_valid),
        .dmd_req_ready  (dmd_req_ready),
        .dmd_req_addr   (dmd_req_addr),
        .dmd_rsp_valid  (dmd_rsp_valid),
        .dmd_rsp_addr   (dmd_rsp_addr),
        .dmd_rsp_data   (dmd_rsp_data),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_pf      (ic_req_pf),
        .ic_rsp_valid   (ic_rsp_valid),
        .ic_rsp_addr    (ic_rsp_addr),
        .ic_rsp_data    (ic_rsp_data),
        .busy           (busy),
        .perf_dmd_cnt   (perf_dmd_cnt),
        .perf_pf_cnt    (perf_pf_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs for the current cycle (icache response included) and
    // move to the sampling point at the falling edge.
    task automatic step(input logic dv, input logic [31:0] da, input logic fl, input logic rok);
        dmd_req_valid = dv;
        dmd_req_addr  = da;
        flush         = fl;
        if (rok && (q_a.size() > 0) && (q_c[0] + LAT <= cyc)) begin
            ic_rsp_valid = 1'b1;
            ic_rsp_addr  = q_a[0];
            ic_rsp_data  = {16{q_a[0]}};
            void'(q_a.pop_front());
            void'(q_c.pop_front());
        end else begin
            ic_rsp_valid = 1'b0;
            ic_rsp_addr  = '0;
            ic_rsp_data  = '0;
        end
        @(negedge clk);
    endtask

    // Log any issued request into the icache model and advance one cycle.
    task automatic adv();
        if (ic_req_valid) begin
            q_a.push_back(ic_req_addr);
            q_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic exp_req(input string tag, input logic v, input logic [31:0] a, input logic pf);
        chk({tag, "_valid"}, 64'(ic_req_valid), 64'(v));
        if (v) begin
            chk({tag, "_addr"}, 64'(ic_req_addr), 64'(a));
            chk({tag, "_pf"}, 64'(ic_req_pf), 64'(pf));
        end
    endtask

    task automatic exp_rsp(input string tag, input logic v, input logic [31:0] a);
        chk({tag, "_rspv"}, 64'(dmd_rsp_valid), 64'(v));
        if (v) begin
            chk({tag, "_rspa"}, 64'(dmd_rsp_addr), 64'(a));
            chk({tag, "_rspd"}, dmd_rsp_data[63:0], {a, a});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            adv();
        end
    endtask

    task automatic do_reset(input string tag);
        dmd_req_valid = 1'b0;
        dmd_req_addr  = '0;
        flush         = 1'b0;
        ic_rsp_valid  = 1'b0;
        ic_rsp_addr   = '0;
        ic_rsp_data   = '0;
        q_a.delete();
        q_c.delete();
        reset_n = 1'b0;
        #1;
        chk({tag, "_rst_ready"}, 64'(dmd_req_ready), 64'd0);
        chk({tag, "_rst_icv"}, 64'(ic_req_valid), 64'd0);
        chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rst_perf"}, {perf_dmd_cnt, perf_pf_cnt | perf_stall_cnt}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk({tag, "_post_ready"}, 64'(dmd_req_ready), 64'd1);
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        // ---------------- Test 1: single demand, two prefetches ---------
        do_reset("t1");
        step(1'b1, 32'h0000_1000, 1'b0, 1'b1); exp_req("t1c0", 1'b1, 32'h0000_1000, 1'b0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t1c1", 1'b1, 32'h0000_1040, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t1c2", 1'b1, 32'h0000_1080, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t1c3", 1'b0, 32'h0, 1'b0);
        chk("t1c3_busy", 64'(busy), 64'd1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t1c4", 1'b0, 32'h0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t1c5", 1'b1, 32'h0000_1000); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t1c6", 1'b0, 32'h0);
        chk("t1c6_icrsp", 64'(ic_rsp_valid), 64'd1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t1c7", 1'b0, 32'h0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); chk("t1c8_busy", 64'(busy), 64'd0);
`ifdef ICARB_PERF_EN
        chk("t1_perf_dmd", 64'(perf_dmd_cnt), 64'd1);
        chk("t1_perf_pf", 64'(perf_pf_cnt), 64'd2);
        chk("t1_perf_stall", 64'(perf_stall_cnt), 64'd0);
`else
        chk("t1_perf_dmd", 64'(perf_dmd_cnt), 64'd0);
        chk("t1_perf_pf", 64'(perf_pf_cnt), 64'd0);
        chk("t1_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
        adv();
        $display("test1 single demand: done at cycle %0d", cyc);

        // ---------------- Test 2: back-to-back demands, no duplicate ---
        do_reset("t2");
        step(1'b1, 32'h0000_1000, 1'b0, 1'b1); exp_req("t2c0", 1'b1, 32'h0000_1000, 1'b0); adv();
        step(1'b1, 32'h0000_1040, 1'b0, 1'b1); exp_req("t2c1", 1'b1, 32'h0000_1040, 1'b0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t2c2", 1'b1, 32'h0000_1080, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t2c3", 1'b1, 32'h0000_10C0, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t2c4", 1'b0, 32'h0, 1'b0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t2c5", 1'b1, 32'h0000_1000); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t2c6", 1'b1, 32'h0000_1040); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t2c7", 1'b0, 32'h0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t2c8", 1'b0, 32'h0); adv();
        idle(2);
        $display("test2 back-to-back demands: done at cycle %0d", cyc);

        // ---------------- Test 3: flush cancels the prefetch window -----
        do_reset("t3");
        step(1'b1, 32'h0000_2000, 1'b0, 1'b1); exp_req("t3c0", 1'b1, 32'h0000_2000, 1'b0); adv();
        step(1'b0, 32'h0, 1'b1, 1'b1); exp_req("t3c1", 1'b0, 32'h0, 1'b0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t3c2", 1'b0, 32'h0, 1'b0);
        chk("t3c2_busy", 64'(busy), 64'd1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t3c3", 1'b0, 32'h0, 1'b0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t3c5", 1'b1, 32'h0000_2000); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); chk("t3c6_busy", 64'(busy), 64'd0); adv();
        $display("test3 flush: done at cycle %0d", cyc);

        // ---------------- Test 4: outstanding limit ----------------------
        do_reset("t4");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h0000_3000 + 32'(i * 64), 1'b0, 1'b0);
            chk("t4_fill_ready", 64'(dmd_req_ready), 64'd1);
            exp_req("t4_fill", 1'b1, 32'h0000_3000 + 32'(i * 64), 1'b0);
            adv();
        end
        step(1'b1, 32'h0000_3200, 1'b0, 1'b0);
        chk("t4c8_ready", 64'(dmd_req_ready), 64'd0);
        exp_req("t4c8", 1'b0, 32'h0, 1'b0); adv();
        step(1'b1, 32'h0000_3200, 1'b0, 1'b1);
        chk("t4c9_ready", 64'(dmd_req_ready), 64'd0);
        exp_req("t4c9", 1'b0, 32'h0, 1'b0);
        exp_rsp("t4c9", 1'b1, 32'h0000_3000); adv();
        step(1'b1, 32'h0000_3200, 1'b0, 1'b1);
        chk("t4c10_ready", 64'(dmd_req_ready), 64'd1);
        exp_req("t4c10", 1'b1, 32'h0000_3200, 1'b0);
        exp_rsp("t4c10", 1'b1, 32'h0000_3040); adv();
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4c11_ready", 64'(dmd_req_ready), 64'd1);
        exp_req("t4c11", 1'b1, 32'h0000_3240, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4c12_ready", 64'(dmd_req_ready), 64'd0);
        exp_req("t4c12", 1'b0, 32'h0, 1'b0); adv();
        idle(24);
        chk("t4_drain_busy", 64'(busy), 64'd0);
`ifdef ICARB_PERF_EN
        chk("t4_perf_stall", 64'(perf_stall_cnt), 64'd2);
`else
        chk("t4_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
        $display("test4 outstanding limit: done at cycle %0d", cyc);

        // ---------------- Test 5: line address wrap-around ---------------
        do_reset("t5");
        step(1'b1, 32'hFFFF_FFC0, 1'b0, 1'b1); exp_req("t5c0", 1'b1, 32'hFFFF_FFC0, 1'b0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t5c1", 1'b1, 32'h0000_0000, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t5c2", 1'b1, 32'h0000_0040, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_req("t5c3", 1'b0, 32'h0, 1'b0); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); adv();
        step(1'b0, 32'h0, 1'b0, 1'b1); exp_rsp("t5c5", 1'b1, 32'hFFFF_FFC0); adv();
        idle(4);
        chk("t5_busy", 64'(busy), 64'd0);
        $display("test5 wrap-around: done at cycle %0d", cyc);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
